// File: rtl/kf_pkg.sv
// Shared types and default sizes for the Kalman covariance sequencer.
package kf_pkg;

   localparam int KF_WIDTH   = 16;
   localparam int KF_NOS     = 4;
   localparam int KF_NOO     = 2;
   localparam int KF_TIMEOUT = 32;
   localparam int KF_ITER_W  = 16;

   typedef enum logic [2:0] {
      INIT    = 3'd0,
      IDLE    = 3'd1,
      FIRST   = 3'd2,
      RESTART = 3'd3,
      WAIT_K  = 3'd4,
      WAIT_P  = 3'd5,
      ERR     = 3'd6
   } kf_seq_state_t;

   typedef logic [KF_NOS-1:0][KF_NOO-1:0][KF_WIDTH-1:0] kf_gain_t;

   function automatic logic is_busy(input kf_seq_state_t s);
      return (s == FIRST) || (s == RESTART) || (s == WAIT_K) || (s == WAIT_P);
   endfunction

   function automatic logic is_wait(input kf_seq_state_t s);
      return (s == WAIT_K) || (s == WAIT_P);
   endfunction

endpackage

// File: rtl/kf_watchdog.sv
// Loadable up-counter that flags a generator stuck in one wait state.
// expired means the current cycle is the TIMEOUT-th cycle since the last clear.
module kf_watchdog #(
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic             expired
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (enable && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/kf_cov_sequencer.sv
// Drives covariance_matrix_generator one measurement step at a time and
// buffers the resulting 4x2 gain for a valid/ready consumer.
module kf_cov_sequencer
   import kf_pkg::*;
#(
   parameter int WIDTH   = KF_WIDTH,
   parameter int nos     = KF_NOS,
   parameter int noo     = KF_NOO,
   parameter int TIMEOUT = KF_TIMEOUT,
   parameter int ITER_W  = KF_ITER_W
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                meas_valid,
   output logic                                meas_ready,
   output logic                                start_kg,
   output logic                                restart_calc,
   output logic                                cov_reset,
   input  logic                                end_kg,
   input  logic                                end_pnk,
   input  logic [nos-1:0][noo-1:0][WIDTH-1:0]  gain_in,
   output logic [nos-1:0][noo-1:0][WIDTH-1:0]  gain_out,
   output logic                                gain_valid,
   input  logic                                gain_ready,
   output logic                                busy,
   output logic [ITER_W-1:0]                   iter_count,
   output logic                                timeout_err,
   input  logic                                clear_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   kf_seq_state_t state_reg, state_next;

   logic              primed_reg;
   logic              meas_ready_reg, meas_ready_next;
   logic              start_kg_reg, start_kg_next;
   logic              restart_calc_reg, restart_calc_next;
   logic              cov_reset_reg, cov_reset_next;
   logic              busy_reg, busy_next;
   logic              gain_valid_reg, gain_valid_next;
   logic              timeout_err_reg, timeout_err_next;
   logic [ITER_W-1:0] iter_count_reg;

   logic accept;
   logic capture;
   logic wd_clear;
   logic wd_enable;
   logic wd_expired;

   assign accept  = (state_reg == IDLE) && meas_valid && meas_ready_reg;
   assign capture = (state_reg == WAIT_K) && end_kg;

   // Restart the count on every entry into a wait state, run while waiting.
   assign wd_clear  = (state_next != state_reg) && is_wait(state_next);
   assign wd_enable = is_wait(state_reg);

   kf_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (WD_W)
   ) u_watchdog (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (wd_clear),
      .load       (1'b0),
      .load_value ('0),
      .enable     (wd_enable),
      .expired    (wd_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= INIT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         INIT: state_next = IDLE;
         IDLE: begin
            if (accept) begin
               if (!primed_reg) begin
                  state_next = FIRST;
               end else if (!end_pnk) begin
                  // Generator should be parked here; anything else means lost sync.
                  state_next = ERR;
               end else begin
                  state_next = RESTART;
               end
            end
         end
         FIRST:   state_next = WAIT_K;
         RESTART: state_next = WAIT_K;
         WAIT_K: begin
            if (end_kg) begin
               state_next = WAIT_P;
            end else if (wd_expired) begin
               state_next = ERR;
            end
         end
         WAIT_P: begin
            if (end_pnk) begin
               state_next = IDLE;
            end else if (wd_expired) begin
               state_next = ERR;
            end
         end
         ERR:     state_next = INIT;
         default: state_next = INIT;
      endcase
   end

   // Outputs are decoded from the next state so that every port is a flop.
   always_comb begin
      gain_valid_next = gain_valid_reg;
      if (gain_valid_reg && gain_ready) begin
         gain_valid_next = 1'b0;
      end
      if (capture) begin
         gain_valid_next = 1'b1;
      end
      if (state_next == ERR) begin
         gain_valid_next = 1'b0;
      end

      timeout_err_next = timeout_err_reg;
      if (clear_err) begin
         timeout_err_next = 1'b0;
      end
      if (state_next == ERR) begin
         timeout_err_next = 1'b1;
      end

      start_kg_next     = (state_next == FIRST);
      restart_calc_next = (state_next == RESTART);
      cov_reset_next    = (state_next == INIT);
      busy_next         = is_busy(state_next);
      meas_ready_next   = (state_next == IDLE) && !gain_valid_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meas_ready_reg   <= 1'b0;
         start_kg_reg     <= 1'b0;
         restart_calc_reg <= 1'b0;
         cov_reset_reg    <= 1'b1;
         busy_reg         <= 1'b0;
         gain_valid_reg   <= 1'b0;
         timeout_err_reg  <= 1'b0;
      end else begin
         meas_ready_reg   <= meas_ready_next;
         start_kg_reg     <= start_kg_next;
         restart_calc_reg <= restart_calc_next;
         cov_reset_reg    <= cov_reset_next;
         busy_reg         <= busy_next;
         gain_valid_reg   <= gain_valid_next;
         timeout_err_reg  <= timeout_err_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         primed_reg     <= 1'b0;
         iter_count_reg <= '0;
      end else begin
         if (state_reg == INIT) begin
            primed_reg <= 1'b0;
         end else if (state_reg == FIRST) begin
            primed_reg <= 1'b1;
         end
         if ((state_reg == WAIT_P) && end_pnk) begin
            iter_count_reg <= iter_count_reg + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < nos; gi++) begin : g_row
      for (genvar gj = 0; gj < noo; gj++) begin : g_col
         logic [WIDTH-1:0] elem_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               elem_reg <= '0;
            end else if (capture) begin
               elem_reg <= gain_in[gi][gj];
            end
         end

         assign gain_out[gi][gj] = elem_reg;
      end
   end

   assign meas_ready   = meas_ready_reg;
   assign start_kg     = start_kg_reg;
   assign restart_calc = restart_calc_reg;
   assign cov_reset    = cov_reset_reg;
   assign busy         = busy_reg;
   assign gain_valid   = gain_valid_reg;
   assign timeout_err  = timeout_err_reg;
   assign iter_count   = iter_count_reg;

endmodule

// File: tb/tb_kf_cov_sequencer.sv
// Directed bench for kf_cov_sequencer with a behavioural covariance generator
// and a queue of expected gains popped at each delivery handshake.
`timescale 1ns/1ps
module tb_kf_cov_sequencer;
   import kf_pkg::*;

   localparam int TB_ITER_W  = 4;
   localparam int TB_TIMEOUT = 32;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 meas_valid;
   logic                 meas_ready;
   logic                 start_kg;
   logic                 restart_calc;
   logic                 cov_reset;
   logic                 end_kg;
   logic                 end_pnk;
   kf_gain_t             gain_in;
   kf_gain_t             gain_out;
   logic                 gain_valid;
   logic                 gain_ready;
   logic                 busy;
   logic [TB_ITER_W-1:0] iter_count;
   logic                 timeout_err;
   logic                 clear_err;

   int       n_checks = 0;
   int       n_errors = 0;
   int       step_no  = 0;
   int       exp_iter = 0;
   kf_gain_t exp_q[$];

   always #5 clk = ~clk;

   kf_cov_sequencer #(
      .WIDTH   (KF_WIDTH),
      .nos     (KF_NOS),
      .noo     (KF_NOO),
      .TIMEOUT (TB_TIMEOUT),
      .ITER_W  (TB_ITER_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .meas_valid   (meas_valid),
      .meas_ready   (meas_ready),
      .start_kg     (start_kg),
      .restart_calc (restart_calc),
      .cov_reset    (cov_reset),
      .end_kg       (end_kg),
      .end_pnk      (end_pnk),
      .gain_in      (gain_in),
      .gain_out     (gain_out),
      .gain_valid   (gain_valid),
      .gain_ready   (gain_ready),
      .busy         (busy),
      .iter_count   (iter_count),
      .timeout_err  (timeout_err),
      .clear_err    (clear_err)
   );

   function automatic kf_gain_t make_gain(input int seed);
      kf_gain_t g;
      for (int i = 0; i < KF_NOS; i++) begin
         for (int j = 0; j < KF_NOO; j++) begin
            g[i][j] = 16'((seed * 257) + (i * 16) + (j * 3) + 7);
         end
      end
      return g;
   endfunction

   // Behavioural generator: 9 / 8 cycles to end_kg, 4 more to end_pnk, then parked.
   typedef enum logic [1:0] {G_OFF, G_K, G_P, G_PARK} gen_phase_t;
   gen_phase_t gen_phase;
   int         gen_cnt;
   int         gen_seed = 0;
   logic       gen_hang;
   logic       gen_unpark;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gen_phase <= G_OFF;
         gen_cnt   <= 0;
      end else if (cov_reset) begin
         gen_phase <= G_OFF;
         gen_cnt   <= 0;
      end else if (start_kg) begin
         gen_phase <= G_K;
         gen_cnt   <= 9;
         gen_seed  <= gen_seed + 1;
      end else if (restart_calc) begin
         gen_phase <= G_K;
         gen_cnt   <= 8;
         gen_seed  <= gen_seed + 1;
      end else if (gen_phase == G_K && !gen_hang) begin
         if (gen_cnt == 1) begin
            gen_phase <= G_P;
            gen_cnt   <= 4;
         end else begin
            gen_cnt <= gen_cnt - 1;
         end
      end else if (gen_phase == G_P) begin
         if (gen_cnt == 1) gen_phase <= G_PARK;
         else gen_cnt <= gen_cnt - 1;
      end
   end

   assign end_kg  = (gen_phase == G_K) && (gen_cnt == 1) && !gen_hang;
   assign end_pnk = ((gen_phase == G_P) && (gen_cnt == 1)) || ((gen_phase == G_PARK) && !gen_unpark);
   assign gain_in = end_kg ? make_gain(gen_seed) : ~make_gain(gen_seed);

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input bit exp_first, input bit hang, input string tag);
      int k;
      k = 0;
      while (!meas_ready && k < 20) begin
         tick();
         k++;
      end
      check({tag, " ready before accept"}, meas_ready, 1'b1);
      meas_valid = 1'b1;
      tick();
      meas_valid = 1'b0;
      step_no++;
      if (!hang) exp_q.push_back(make_gain(step_no));
      $display("step %0d %s: start_kg=%0b restart_calc=%0b", step_no, tag, start_kg, restart_calc);
      check({tag, " start_kg"}, start_kg, exp_first);
      check({tag, " restart_calc"}, restart_calc, !exp_first);
      check({tag, " busy/ready after accept"}, {busy, meas_ready}, 2'b10);
   endtask

   task automatic await_gain(input int exp_lat, input string tag);
      int k;
      k = 0;
      while (!gain_valid && k < 40) begin
         tick();
         k++;
      end
      check({tag, " pulse-to-gain_valid cycles"}, k, exp_lat);
   endtask

   task automatic await_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 40) begin
         tick();
         k++;
      end
      exp_iter = (exp_iter + 1) % (1 << TB_ITER_W);
      check({tag, " gain_valid-to-idle cycles"}, k, 4);
      check({tag, " iter_count"}, iter_count, exp_iter);
   endtask

   task automatic deliver(input string tag);
      kf_gain_t e;
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check({tag, " gain_valid pending"}, gain_valid, 1'b1);
      check({tag, " gain_out"}, gain_out, e);
      gain_ready = 1'b1;
      tick();
      gain_ready = 1'b0;
      check({tag, " valid/ready after delivery"}, {gain_valid, meas_ready}, 2'b01);
   endtask

   task automatic run_step(input bit exp_first, input string tag);
      launch(exp_first, 1'b0, tag);
      await_gain(exp_first ? 10 : 9, tag);
      await_idle(tag);
      deliver(tag);
   endtask

   initial begin
      #300000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      kf_gain_t held;
      bit       stable;
      int       k;

      reset_n    = 1'b0;
      meas_valid = 1'b0;
      gain_ready = 1'b0;
      clear_err  = 1'b0;
      gen_hang   = 1'b0;
      gen_unpark = 1'b0;

      // Reset values and release.
      repeat (3) @(posedge clk);
      #1;
      check("reset cov_reset", cov_reset, 1'b1);
      check("reset flags", {meas_ready, start_kg, restart_calc, busy, gain_valid, timeout_err}, 6'b0);
      check("reset gain_out", gain_out, '0);
      check("reset iter_count", iter_count, 0);
      reset_n = 1'b1;
      #2;
      check("release cycle", {cov_reset, start_kg, restart_calc}, 3'b100);
      tick();
      check("after INIT", {cov_reset, start_kg, restart_calc, meas_ready}, 4'b0001);

      run_step(1'b1, "first");
      run_step(1'b0, "second");

      // Back-pressure: hold gain_ready low while the gain is pending.
      launch(1'b0, 1'b0, "hold");
      await_gain(9, "hold");
      held = gain_out;
      await_idle("hold");
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (gain_out !== held || gain_valid !== 1'b1 || meas_ready !== 1'b0) stable = 1'b0;
         tick();
      end
      $display("hold: gain_out held over 20 cycles = %0b", stable);
      check("hold gain_out stable, meas_ready low", stable, 1'b1);
      deliver("hold");

      // Hung generator: watchdog fires after 32 cycles in WAIT_K.
      gen_hang = 1'b1;
      launch(1'b0, 1'b1, "hang");
      k = 0;
      while (!timeout_err && k < 60) begin
         tick();
         k++;
      end
      $display("hang: timeout_err after %0d cycles", k);
      check("hang pulse-to-timeout_err cycles", k, 33);
      check("hang busy/gain_valid in ERR", {busy, gain_valid}, 2'b00);
      tick();
      check("hang cov_reset pulse", cov_reset, 1'b1);
      gen_hang = 1'b0;
      tick();
      check("hang back in IDLE", {cov_reset, timeout_err, meas_ready}, 3'b011);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("clear_err clears flag", timeout_err, 1'b0);
      run_step(1'b1, "after-hang");

      // Desynchronised generator: not parked on accept; set beats clear.
      gen_unpark = 1'b1;
      clear_err  = 1'b1;
      meas_valid = 1'b1;
      tick();
      meas_valid = 1'b0;
      $display("desync: timeout_err=%0b busy=%0b", timeout_err, busy);
      check("desync ERR outputs", {start_kg, restart_calc, busy, timeout_err}, 4'b0001);
      tick();
      check("desync INIT, clear applied", {cov_reset, timeout_err}, 2'b10);
      clear_err  = 1'b0;
      gen_unpark = 1'b0;
      tick();
      run_step(1'b1, "after-desync");

      // Asynchronous reset during WAIT_P.
      launch(1'b0, 1'b0, "abort");
      await_gain(9, "abort");
      reset_n = 1'b0;
      #1;
      $display("abort: reset asserted mid-step, gain_valid=%0b busy=%0b", gain_valid, busy);
      check("abort cov_reset", cov_reset, 1'b1);
      check("abort flags", {meas_ready, start_kg, restart_calc, busy, gain_valid, timeout_err}, 6'b0);
      check("abort gain_out", gain_out, '0);
      check("abort iter_count", iter_count, 0);
      void'(exp_q.pop_back());
      exp_iter = 0;
      tick();
      tick();
      reset_n = 1'b1;
      #2;
      check("abort release no pulse", {start_kg, restart_calc}, 2'b00);
      tick();
      check("abort after INIT", {cov_reset, start_kg, restart_calc, meas_ready}, 4'b0001);

      // Seventeen steps from reset wrap the 4-bit iteration counter.
      run_step(1'b1, "wrap 1");
      for (int s = 2; s <= 17; s++) begin
         run_step(1'b0, $sformatf("wrap %0d", s));
      end
      check("scoreboard drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
